div_seq: RTL and testbench
==========================

# div_seq

Multi-cycle 32-bit integer divide sequencer for the EX stage of the 5-stage MIPS pipeline. Accepts a DIV/DIVU request from EX, runs a one-bit-per-cycle restoring division, and raises `stallreq` into the stall controller until the 64-bit {remainder, quotient} result is ready for the HI/LO write. Supports annul on flush and holds its result while EX is stalled by another source.

## Interface
Parameters: none. State encodings and widths come from `lib/defines.vh`.
- `clk`  in  1  system clock
- `rst`  in  1  synchronous reset, active-high
- `stall`  in  `StallBus`  pipeline stall bus; `stall[3]==`Stop` means EX is held
- `start`  in  1  EX has a DIV/DIVU in flight (held high by EX while stalled)
- `signed_div`  in  1  1 = DIV (signed), 0 = DIVU
- `opdata1`  in  32  dividend (rs value, forwarded)
- `opdata2`  in  32  divisor (rt value, forwarded)
- `annul`  in  1  abort current division (flush)
- `result`  out  64  {remainder[63:32] → HI, quotient[31:0] → LO}
- `ready`  out  1  result valid
- `stallreq`  out  1  stall request to the stall controller (combinational)

## Operation
- States: `DivFree`, `DivByZero`, `DivOn`, `DivEnd`.
- `DivFree`:
  - If `start && !annul` and `opdata2==0` → `DivByZero`.
  - If `start && !annul` and `opdata2!=0`: latch the operands (absolute values when `signed_div`), latch the sign flags and `signed_div`, clear the iteration counter → `DivOn`.
  - Otherwise stay.
- `DivByZero`: internal quotient/remainder = 0 → `DivEnd`.
- `DivOn`:
  - `annul` → `DivFree`; counter and partial results discarded.
  - Counter 0..31: one restoring step per cycle (shift the partial remainder left, trial-subtract the divisor, shift a quotient bit in).
  - Counter == 32: apply the sign fix → `DivEnd`.
  - Sign fix, signed only: quotient negated iff sign(a)^sign(b); remainder takes sign(a).
  - Unsigned: no fix.
- `DivEnd`:
  - `ready=1`, `result` valid.
  - If `stall[3]==`Stop`: stay, result held stable.
  - Else → `DivFree`, with `result` and `ready` cleared next cycle.
  - `annul` in `DivEnd` → `DivFree`.
- `stallreq` = (`DivFree` && `start` && `!annul`) || `DivByZero` || `DivOn`. It is 0 in `DivEnd`.
- Operand changes after the latch cycle are ignored.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): quotient 0x80000000, remainder 0. No trap.

## Timing
- Reset: state `DivFree`; `result`=0, `ready`=0, `stallreq`=0; counter 0. Reset mid-division aborts it; a new request is accepted the cycle after `rst` deasserts.
- Normal divide, with cycle 0 = first `start` cycle in `DivFree`:
  - `DivOn` covers cycles 1–33 (32 steps + 1 fix cycle).
  - `DivEnd` at cycle 34.
  - `stallreq` high in cycles 0–33.
- Divide by zero: `DivByZero` at cycle 1, `DivEnd` at cycle 2; `stallreq` high in cycles 0–1.
- Back-to-back divides: after `DivEnd` → `DivFree`, a `start` still high in `DivFree` is a new division with fresh operands. There are no idle-bubble requirements.
- `annul` takes priority over `start` and over iteration in every state.

## Structure
- `lib/defines.vh` additions:
  - `DivFree` 2'b00, `DivByZero` 2'b01, `DivOn` 2'b10, `DivEnd` 2'b11
  - `DivResultReady` 1'b1, `DivResultNotReady` 1'b0
  - existing `Stop`/`NoStop`/`StallBus`
- One sub-module, `div_step`: purely combinational single restoring step on a 65-bit {remainder, dividend} register against a 32-bit divisor. It returns the next register value.
- The FSM, counter, latches and sign fix live in `div_seq`.

## Test plan
- DIVU 100/7 (`signed_div`=0) → `stallreq` high in cycles 0–33; at cycle 34 `ready`=1, `result`=64'h00000002_0000000E.
- DIV −7/2 (0xFFFFFFF9, 0x00000002) → `result`=64'hFFFFFFFF_FFFFFFFD.
- DIV 0x80000000 / 0xFFFFFFFF → `result`=64'h00000000_80000000.
- DIV 5/0 → `ready` at cycle 2, `result`=0, `stallreq` low from cycle 2.
- `annul` at cycle 10 of a divide → `DivFree` next cycle, `ready` never asserts. A new request 12/4 then yields `result`=64'h00000000_00000003.
- `stall[3]=`Stop` for 3 cycles in `DivEnd` → `ready`/`result` held all 3 cycles. On release → `DivFree` and outputs cleared. `rst` asserted at cycle 20 of a divide → all outputs 0 the following cycle.

Source files
------------

// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared state encodings, stall-bus constants and helpers for the divide sequencer
package div_seq_pkg;
  localparam int STALL_W = 6;
  localparam int STALL_EX = 3;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam logic DIV_RESULT_READY = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic s);
    return (s && v[31]) ? -v : v;
  endfunction
endpackage

// File: rtl/div_seq_if.sv
// div_seq_if: EX-stage request/result bundle between the pipeline and the divide sequencer
interface div_seq_if;
  import div_seq_pkg::*;
  logic [STALL_W-1:0] stall;
  logic start;
  logic signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic annul;
  logic [63:0] result;
  logic ready;
  logic stallreq;
  modport master (output stall, start, signed_div, opdata1, opdata2, annul, input result, ready, stallreq);
  modport slave (input stall, start, signed_div, opdata1, opdata2, annul, output result, ready, stallreq);
endinterface

// File: rtl/div_step.sv
// div_step: one restoring-division step on {remainder, dividend} against a 32-bit divisor
module div_step (
  input  logic [64:0] acc_i,
  input  logic [31:0] divisor_i,
  output logic [64:0] acc_o
);
  logic [64:0] sh;
  logic [33:0] diff;
  always_comb begin
    sh = acc_i << 1;
    diff = {1'b0, sh[64:32]} - {2'b0, divisor_i};
    acc_o = diff[33] ? sh : {diff[32:0], sh[31:0] | 32'd1};
  end
endmodule

// File: rtl/div_seq.sv
// div_seq: multi-cycle signed/unsigned 32-bit divider with stall request, annul and result hold
module div_seq
  import div_seq_pkg::*;
(
  input logic clk,
  input logic rst,
  div_seq_if.slave bus
);
  div_state_e state_q;
  logic [5:0] cnt_q;
  logic [64:0] acc_q, acc_d;
  logic [31:0] dvs_q;
  logic sa_q, sb_q, sdiv_q;
  logic [63:0] result_q;
  logic ready_q;
  logic [31:0] q_fix, r_fix;
  logic go;
  div_step u_step (.acc_i(acc_q), .divisor_i(dvs_q), .acc_o(acc_d));
  // Remainder follows the dividend's sign; quotient is negative when operand signs differ.
  always_comb begin
    q_fix = (sdiv_q && (sa_q ^ sb_q)) ? -acc_q[31:0] : acc_q[31:0];
    r_fix = (sdiv_q && sa_q) ? -acc_q[63:32] : acc_q[63:32];
  end
  assign go = bus.start && !bus.annul;
  assign bus.stallreq = (state_q == DIV_FREE && go) || state_q == DIV_BY_ZERO || state_q == DIV_ON;
  assign bus.result = result_q;
  assign bus.ready = ready_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_FREE;
      cnt_q <= '0;
      acc_q <= '0;
      dvs_q <= '0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      sdiv_q <= 1'b0;
      result_q <= '0;
      ready_q <= DIV_RESULT_NOT_READY;
    end else if (bus.annul) begin
      state_q <= DIV_FREE;
      cnt_q <= '0;
      result_q <= '0;
      ready_q <= DIV_RESULT_NOT_READY;
    end else begin
      case (state_q)
        DIV_FREE: begin
          if (bus.start && bus.opdata2 == '0) begin
            state_q <= DIV_BY_ZERO;
          end else if (bus.start) begin
            state_q <= DIV_ON;
            cnt_q <= '0;
            acc_q <= {33'b0, abs32(bus.opdata1, bus.signed_div)};
            dvs_q <= abs32(bus.opdata2, bus.signed_div);
            sa_q <= bus.opdata1[31];
            sb_q <= bus.opdata2[31];
            sdiv_q <= bus.signed_div;
          end
        end
        DIV_BY_ZERO: begin
          result_q <= '0;
          ready_q <= DIV_RESULT_READY;
          state_q <= DIV_END;
        end
        DIV_ON: begin
          if (cnt_q == 6'd32) begin
            result_q <= {r_fix, q_fix};
            ready_q <= DIV_RESULT_READY;
            state_q <= DIV_END;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 6'd1;
          end
        end
        default: begin
          if (bus.stall[STALL_EX] != STOP) begin
            state_q <= DIV_FREE;
            result_q <= '0;
            ready_q <= DIV_RESULT_NOT_READY;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed-vector bench for div_seq with latency, hold, annul and reset checks
module tb_div_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  div_seq_if bus ();
  div_seq dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wait_result(input string tag, input logic [63:0] exp_res, input int exp_lat);
    int n;
    logic bad;
    n = 0;
    bad = 1'b0;
    @(negedge clk);
    while (!bus.ready && n < 40) begin
      if (bus.stallreq !== 1'b1) bad = 1'b1;
      n++;
      if (n == 2) begin
        bus.opdata1 = $urandom;
        bus.opdata2 = $urandom | 32'd1;
      end
      @(negedge clk);
    end
    chk({tag, "_busy_stallreq"}, {63'd0, bad}, 64'd0);
    chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
    chk({tag, "_result"}, bus.result, exp_res);
    chk({tag, "_end_stallreq"}, {63'd0, bus.stallreq}, 64'd0);
  endtask
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [63:0] exp_res, input int exp_lat);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.signed_div = s;
    bus.opdata1 = a;
    bus.opdata2 = b;
    wait_result(tag, exp_res, exp_lat);
    bus.start = 1'b0;
    @(negedge clk);
    chk({tag, "_cleared_ready"}, {63'd0, bus.ready}, 64'd0);
    chk({tag, "_cleared_result"}, bus.result, 64'd0);
  endtask
  initial begin
    bus.stall = '0;
    bus.start = 1'b0;
    bus.signed_div = 1'b0;
    bus.opdata1 = '0;
    bus.opdata2 = '0;
    bus.annul = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {63'd0, bus.ready}, 64'd0);
    chk("reset_result", bus.result, 64'd0);
    chk("reset_stallreq", {63'd0, bus.stallreq}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_div("divu_100_7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 34);
    do_div("div_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 34);
    do_div("div_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 34);
    do_div("div_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 34);
    do_div("div_m100_m7", 32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 64'hFFFFFFFE_0000000E, 34);
    do_div("divu_big", 32'hFFFFFFFF, 32'h10, 1'b0, 64'h0000000F_0FFFFFFF, 34);
    do_div("div_by_zero", 32'd5, 32'd0, 1'b1, 64'd0, 2);
    // Back-to-back: start stays high across DivEnd and fresh operands are latched.
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.signed_div = 1'b0;
    bus.opdata1 = 32'd100;
    bus.opdata2 = 32'd7;
    wait_result("b2b_first", 64'h00000002_0000000E, 34);
    bus.opdata1 = 32'd9;
    bus.opdata2 = 32'd2;
    wait_result("b2b_second", 64'h00000001_00000004, 34);
    bus.start = 1'b0;
    @(negedge clk);
    chk("b2b_cleared_ready", {63'd0, bus.ready}, 64'd0);
    // Annul in the middle of a divide.
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.signed_div = 1'b0;
    bus.opdata1 = 32'd1000;
    bus.opdata2 = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    bus.annul = 1'b1;
    @(negedge clk);
    chk("annul_c10_stallreq", {63'd0, bus.stallreq}, 64'd1);
    @(posedge clk);
    #1;
    bus.annul = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("annul_c11_stallreq", {63'd0, bus.stallreq}, 64'd0);
    begin
      logic seen;
      seen = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (bus.ready !== 1'b0) seen = 1'b1;
      end
      chk("annul_no_ready", {63'd0, seen}, 64'd0);
    end
    do_div("after_annul_12_4", 32'd12, 32'd4, 1'b0, 64'h00000000_00000003, 34);
    // Hold in DivEnd while EX is stalled.
    @(posedge clk);
    #1;
    bus.stall = 6'b001000;
    bus.start = 1'b1;
    bus.signed_div = 1'b1;
    bus.opdata1 = 32'd20;
    bus.opdata2 = 32'd6;
    wait_result("hold_c34", 64'h00000002_00000003, 34);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("hold_ready_%0d", i), {63'd0, bus.ready}, 64'd1);
      chk($sformatf("hold_result_%0d", i), bus.result, 64'h00000002_00000003);
      chk($sformatf("hold_stallreq_%0d", i), {63'd0, bus.stallreq}, 64'd0);
    end
    bus.stall = '0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("release_ready", {63'd0, bus.ready}, 64'd0);
    chk("release_result", bus.result, 64'd0);
    // Reset in the middle of a divide.
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.signed_div = 1'b0;
    bus.opdata1 = 32'd77;
    bus.opdata2 = 32'd5;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_ready", {63'd0, bus.ready}, 64'd0);
    chk("rst_mid_result", bus.result, 64'd0);
    chk("rst_mid_stallreq", {63'd0, bus.stallreq}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.start = 1'b1;
    bus.opdata1 = 32'd12;
    bus.opdata2 = 32'd4;
    wait_result("post_rst_12_4", 64'h00000000_00000003, 34);
    bus.start = 1'b0;
    @(negedge clk);
    chk("post_rst_cleared", {63'd0, bus.ready}, 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
